// File: rtl/fft_frame_scheduler_if.sv
// Handshake bundle between the FFT frame scheduler, the audio FIFO
// read port and the FFT core's config/data/output streams.
interface fft_frame_scheduler_if;
    logic        fifo_rd_empty;
    logic        fifo_rdreq;
    logic [23:0] fifo_rd_data;
    logic        fft_cfg_tvalid;
    logic        fft_cfg_tdata;
    logic        fft_data_tready;
    logic        fft_data_tvalid;
    logic [31:0] fft_data_tdata;
    logic        fft_data_tlast;
    logic        fft_out_tvalid;
    logic        fft_out_tlast;

    modport master (
        input  fifo_rd_empty,
        output fifo_rdreq,
        input  fifo_rd_data,
        output fft_cfg_tvalid,
        output fft_cfg_tdata,
        input  fft_data_tready,
        output fft_data_tvalid,
        output fft_data_tdata,
        output fft_data_tlast,
        input  fft_out_tvalid,
        input  fft_out_tlast
    );

    modport slave (
        output fifo_rd_empty,
        input  fifo_rdreq,
        output fifo_rd_data,
        input  fft_cfg_tvalid,
        input  fft_cfg_tdata,
        output fft_data_tready,
        input  fft_data_tvalid,
        input  fft_data_tdata,
        input  fft_data_tlast,
        output fft_out_tvalid,
        output fft_out_tlast
    );
endinterface

// File: rtl/fft_frame_scheduler.sv
// Packs audio FIFO samples into fixed-length FFT input frames and
// limits the number of frames in flight through the FFT core.
module fft_frame_scheduler #(
    parameter int FFT_LEN  = 1024,
    parameter int LOG2_LEN = 10,
    parameter int MAX_OUT  = 2,
    parameter bit CFG_DIR  = 1'b1
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 enable,
    fft_frame_scheduler_if.master bus,
    output logic                 busy,
    output logic [15:0]          frame_cnt,
    output logic [2:0]           outstanding,
    output logic                 proto_err
);

    typedef enum logic [1:0] {IDLE, CFG, WAIT, STREAM} state_e;

    localparam logic [LOG2_LEN:0]   LEN  = (LOG2_LEN + 1)'(FFT_LEN);
    localparam logic [LOG2_LEN-1:0] LAST = LOG2_LEN'(FFT_LEN - 1);
    localparam logic [2:0]          MAXO = 3'(MAX_OUT);

    state_e              state_q, state_d;
    logic                cfg_q, cfg_d;
    logic                busy_q, busy_d;
    logic [LOG2_LEN:0]   req_cnt_q, req_cnt_d;
    logic [LOG2_LEN-1:0] send_cnt_q, send_cnt_d;
    logic                pend_q, pend_d;
    logic [1:0]          occ_q, occ_d;
    logic [23:0]         buf0_q, buf0_d;
    logic [23:0]         buf1_q, buf1_d;
    logic [2:0]          out_q, out_d;
    logic [15:0]         frame_q, frame_d;
    logic                err_q, err_d;

    logic       tvalid;
    logic       data_hs;
    logic       in_last;
    logic       out_last;
    logic       rdreq;
    logic [2:0] room;

    assign tvalid   = (occ_q != 2'd0);
    assign data_hs  = tvalid && bus.fft_data_tready;
    assign in_last  = data_hs && (send_cnt_q == LAST);
    assign out_last = bus.fft_out_tvalid && bus.fft_out_tlast;

    // Credit the entry leaving this cycle so the skid buffer sustains full rate.
    assign room  = {1'b0, occ_q} - {2'b0, data_hs} + {2'b0, pend_q};
    assign rdreq = (state_q == STREAM) && !bus.fifo_rd_empty
                && (req_cnt_q < LEN) && (room < 3'd2);

    always_comb begin
        state_d    = state_q;
        req_cnt_d  = req_cnt_q;
        send_cnt_d = send_cnt_q;
        pend_d     = rdreq;
        occ_d      = occ_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        out_d      = out_q;
        frame_d    = frame_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE:   if (enable) state_d = CFG;
            CFG:    state_d = WAIT;
            WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (out_q < MAXO) begin
                    state_d    = STREAM;
                    req_cnt_d  = '0;
                    send_cnt_d = '0;
                end
            end
            STREAM: if (in_last) state_d = WAIT;
            default: state_d = IDLE;
        endcase

        if (rdreq) req_cnt_d = req_cnt_q + 1'b1;
        if (data_hs) send_cnt_d = send_cnt_q + 1'b1;

        unique case ({pend_q, data_hs})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) buf0_d = bus.fifo_rd_data;
                else               buf1_d = bus.fifo_rd_data;
            end
            2'b01: begin
                occ_d  = occ_q - 2'd1;
                buf0_d = buf1_q;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = bus.fifo_rd_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = bus.fifo_rd_data;
                end
            end
            default: ;
        endcase

        if (in_last && !out_last) begin
            out_d = out_q + 3'd1;
        end else if (out_last && !in_last) begin
            if (out_q == 3'd0) err_d = 1'b1;
            else               out_d = out_q - 3'd1;
        end

        if (in_last) frame_d = frame_q + 16'd1;

        cfg_d  = (state_q == IDLE) && enable;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cfg_q      <= 1'b0;
            busy_q     <= 1'b0;
            req_cnt_q  <= '0;
            send_cnt_q <= '0;
            pend_q     <= 1'b0;
            occ_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            out_q      <= 3'd0;
            frame_q    <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            busy_q     <= busy_d;
            req_cnt_q  <= req_cnt_d;
            send_cnt_q <= send_cnt_d;
            pend_q     <= pend_d;
            occ_q      <= occ_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            out_q      <= out_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
        end
    end

    assign bus.fifo_rdreq      = rdreq;
    assign bus.fft_cfg_tvalid  = cfg_q;
    assign bus.fft_cfg_tdata   = CFG_DIR;
    assign bus.fft_data_tvalid = tvalid;
    assign bus.fft_data_tdata  = {8'h00, buf0_q};
    assign bus.fft_data_tlast  = tvalid && (send_cnt_q == LAST);

    assign busy        = busy_q;
    assign frame_cnt   = frame_q;
    assign outstanding = out_q;
    assign proto_err   = err_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler with FFT_LEN=8, MAX_OUT=2:
// FIFO model, beat monitor, and a linear sequence of checked steps.
module tb_fft_frame_scheduler;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [2:0]  outstanding;
    logic        proto_err;

    always #10 clk_50m = ~clk_50m;

    fft_frame_scheduler_if bus();

    fft_frame_scheduler #(
        .FFT_LEN  (8),
        .LOG2_LEN (3),
        .MAX_OUT  (2),
        .CFG_DIR  (1'b1)
    ) dut (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .enable      (enable),
        .bus         (bus),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .outstanding (outstanding),
        .proto_err   (proto_err)
    );

    int errors = 0;
    int checks = 0;

    // FIFO model: data appears the cycle after rdreq
    logic [23:0] mem [0:255];
    int          wr_cnt = 0;
    int          rd_ptr = 0;
    logic        flush  = 1'b0;

    assign bus.fifo_rd_empty = (rd_ptr >= wr_cnt);

    always @(posedge clk_50m) begin
        if (flush) begin
            rd_ptr <= wr_cnt;
        end else if (bus.fifo_rdreq) begin
            bus.fifo_rd_data <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Beat monitor, sampled mid-cycle
    logic [31:0] beat_data [0:255];
    logic        beat_last [0:255];
    int          beat_n    = 0;
    int          cfg_cnt   = 0;
    int          stall_cnt = 0;
    int          stab_viol = 0;
    logic        hold_q    = 1'b0;
    logic [31:0] hold_d;
    logic        hold_l;

    always @(negedge clk_50m) begin
        if (bus.fft_cfg_tvalid) cfg_cnt <= cfg_cnt + 1;
        if (bus.fft_data_tvalid && bus.fft_data_tready) begin
            beat_data[beat_n] <= bus.fft_data_tdata;
            beat_last[beat_n] <= bus.fft_data_tlast;
            beat_n <= beat_n + 1;
        end
        if (hold_q && rst_n) begin
            if (!(bus.fft_data_tvalid && bus.fft_data_tdata === hold_d
                  && bus.fft_data_tlast === hold_l))
                stab_viol <= stab_viol + 1;
        end
        if (bus.fft_data_tvalid && !bus.fft_data_tready)
            stall_cnt <= stall_cnt + 1;
        hold_q <= rst_n && bus.fft_data_tvalid && !bus.fft_data_tready;
        hold_d <= bus.fft_data_tdata;
        hold_l <= bus.fft_data_tlast;
    end

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int n, input logic [23:0] first);
        for (int i = 0; i < n; i++) mem[wr_cnt + i] = first + 24'(i);
        wr_cnt += n;
    endtask

    task automatic wait_beats(input int target, input int budget,
                              input string tag);
        int k;
        k = 0;
        while (beat_n < target && k < budget) begin
            @(negedge clk_50m);
            #2;
            k++;
        end
        chk(tag, 32'(beat_n), 32'(target));
    endtask

    task automatic chk_frame(input string tag, input int base, input int n,
                             input logic [23:0] first);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_d%0d", tag, i), beat_data[base + i],
                {8'h00, first + 24'(i)});
            chk($sformatf("%s_l%0d", tag, i), 32'(beat_last[base + i]),
                32'((i % 8) == 7));
        end
    endtask

    task automatic out_pulse();
        bus.fft_out_tvalid = 1'b1;
        bus.fft_out_tlast  = 1'b1;
        tick();
        bus.fft_out_tvalid = 1'b0;
        bus.fft_out_tlast  = 1'b0;
        tick();
    endtask

    initial begin
        int base;
        int cfg0;
        int s0;
        int k;

        rst_n  = 1'b0;
        enable = 1'b0;
        bus.fft_data_tready = 1'b0;
        bus.fft_out_tvalid  = 1'b0;
        bus.fft_out_tlast   = 1'b0;
        tick();
        tick();

        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame", 32'(frame_cnt), 0);
        chk("rst_outst", 32'(outstanding), 0);
        chk("rst_err", 32'(proto_err), 0);
        chk("rst_tvalid", 32'(bus.fft_data_tvalid), 0);
        chk("rst_tlast", 32'(bus.fft_data_tlast), 0);
        chk("rst_rdreq", 32'(bus.fifo_rdreq), 0);
        chk("rst_cfgv", 32'(bus.fft_cfg_tvalid), 0);
        chk("rst_cfgd", 32'(bus.fft_cfg_tdata), 1);

        rst_n = 1'b1;
        tick();

        // basic frame, plus rdreq -> tvalid latency
        push(8, 24'h000001);
        bus.fft_data_tready = 1'b1;
        cfg0 = cfg_cnt;
        base = beat_n;
        enable = 1'b1;
        k = 0;
        while (!bus.fifo_rdreq && k < 20) begin
            @(negedge clk_50m);
            #2;
            k++;
        end
        chk("lat_rdreq", 32'(bus.fifo_rdreq), 1);
        @(negedge clk_50m);
        #2;
        chk("lat_t1", 32'(bus.fft_data_tvalid), 0);
        @(negedge clk_50m);
        #2;
        chk("lat_t2", 32'(bus.fft_data_tvalid), 1);
        wait_beats(base + 8, 50, "basic_beats");
        repeat (3) tick();
        chk("basic_cfg", 32'(cfg_cnt - cfg0), 1);
        chk("basic_frame", 32'(frame_cnt), 1);
        chk("basic_outst", 32'(outstanding), 1);
        chk("basic_busy", 32'(busy), 1);
        chk_frame("basic", base, 8, 24'h000001);

        // backpressure over two frames
        out_pulse();
        chk("bp_outst0", 32'(outstanding), 0);
        bus.fft_data_tready = 1'b0;
        s0 = stall_cnt;
        base = beat_n;
        push(16, 24'h000100);
        k = 0;
        while (beat_n < base + 16 && k < 200) begin
            tick();
            bus.fft_data_tready = ~bus.fft_data_tready;
            k++;
        end
        bus.fft_data_tready = 1'b1;
        chk("bp_beats", 32'(beat_n), 32'(base + 16));
        chk("bp_stalled", 32'(stall_cnt > s0), 1);
        chk("bp_stable", 32'(stab_viol), 0);
        repeat (3) tick();
        chk("bp_frame", 32'(frame_cnt), 3);
        chk("bp_outst", 32'(outstanding), 2);
        chk_frame("bp", base, 16, 24'h000100);

        // throttle at MAX_OUT
        out_pulse();
        out_pulse();
        chk("thr_outst0", 32'(outstanding), 0);
        base = beat_n;
        push(24, 24'h000200);
        wait_beats(base + 16, 100, "thr_beats2");
        repeat (30) tick();
        chk("thr_held", 32'(beat_n), 32'(base + 16));
        chk("thr_outst2", 32'(outstanding), 2);
        chk("thr_busy", 32'(busy), 1);
        chk("thr_rdreq", 32'(bus.fifo_rdreq), 0);
        chk("thr_tvalid", 32'(bus.fft_data_tvalid), 0);
        out_pulse();
        wait_beats(base + 24, 100, "thr_beats3");
        repeat (3) tick();
        chk("thr_outst3", 32'(outstanding), 2);
        chk("thr_frame", 32'(frame_cnt), 6);
        chk_frame("thr", base, 24, 24'h000200);

        // FIFO underrun after sample 3
        out_pulse();
        out_pulse();
        base = beat_n;
        push(3, 24'h000301);
        wait_beats(base + 3, 50, "ur_beats3");
        repeat (10) tick();
        chk("ur_gap_tvalid", 32'(bus.fft_data_tvalid), 0);
        chk("ur_gap_beats", 32'(beat_n), 32'(base + 3));
        push(5, 24'h000304);
        wait_beats(base + 8, 50, "ur_beats8");
        repeat (3) tick();
        chk("ur_frame", 32'(frame_cnt), 7);
        chk("ur_outst", 32'(outstanding), 1);
        chk_frame("ur", base, 8, 24'h000301);

        // enable drop mid-frame, simultaneous in/out tlast
        base = beat_n;
        push(8, 24'h000401);
        wait_beats(base + 4, 50, "en_beats4");
        enable = 1'b0;
        k = 0;
        while (!(bus.fft_data_tvalid && bus.fft_data_tready
                 && bus.fft_data_tlast) && k < 50) begin
            @(negedge clk_50m);
            #2;
            k++;
        end
        chk("en_tlast_seen", 32'(bus.fft_data_tlast), 1);
        bus.fft_out_tvalid = 1'b1;
        bus.fft_out_tlast  = 1'b1;
        tick();
        bus.fft_out_tvalid = 1'b0;
        bus.fft_out_tlast  = 1'b0;
        chk("sim_outst", 32'(outstanding), 1);
        chk("sim_frame", 32'(frame_cnt), 8);
        repeat (3) tick();
        chk("en_busy", 32'(busy), 0);
        chk("en_beats8", 32'(beat_n), 32'(base + 8));
        chk_frame("en", base, 8, 24'h000401);

        // output tlast with nothing outstanding
        out_pulse();
        chk("pe_outst0", 32'(outstanding), 0);
        chk("pe_err0", 32'(proto_err), 0);
        out_pulse();
        chk("pe_outst", 32'(outstanding), 0);
        chk("pe_err1", 32'(proto_err), 1);
        repeat (5) tick();
        chk("pe_sticky", 32'(proto_err), 1);

        // reset mid-frame
        enable = 1'b1;
        base = beat_n;
        push(8, 24'h000501);
        wait_beats(base + 5, 50, "rr_beats5");
        rst_n = 1'b0;
        #1;
        chk("rr_tvalid", 32'(bus.fft_data_tvalid), 0);
        chk("rr_tlast", 32'(bus.fft_data_tlast), 0);
        chk("rr_busy", 32'(busy), 0);
        chk("rr_frame", 32'(frame_cnt), 0);
        chk("rr_outst", 32'(outstanding), 0);
        chk("rr_err", 32'(proto_err), 0);
        enable = 1'b0;
        flush  = 1'b1;
        tick();
        flush  = 1'b0;
        tick();
        chk("rr_nobeats", 32'(beat_n), 32'(base + 5));
        chk_frame("rr", base, 5, 24'h000501);
        rst_n = 1'b1;
        tick();
        cfg0 = cfg_cnt;
        base = beat_n;
        push(8, 24'h000601);
        enable = 1'b1;
        wait_beats(base + 8, 50, "rr2_beats");
        repeat (3) tick();
        chk("rr2_cfg", 32'(cfg_cnt - cfg0), 1);
        chk("rr2_frame", 32'(frame_cnt), 1);
        chk("rr2_outst", 32'(outstanding), 1);
        chk_frame("rr2", base, 8, 24'h000601);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
